// File: rtl/mem_stage_hazard_controller.sv
// mem_stage_hazard_controller: MEM-stage dmem handshake plus freeze/flush/bubble control for the 5-stage pipe.
module mem_stage_hazard_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mem_is_load,
  input  logic                 mem_is_store,
  input  logic                 ex_is_load,
  input  logic [4:0]           ex_write_addr,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rt,
  input  logic                 dmem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 freeze_front,
  output logic                 freeze_back,
  output logic                 idex_flush,
  output logic                 memwb_bubble,
  output logic                 mem_error,
  output logic [CNT_WIDTH-1:0] stall_cycle_count
);
  typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;
  localparam logic [15:0] LIM = 16'(TIMEOUT_CYCLES - 1);
  state_t state, state_next;
  logic [15:0] tmo, tmo_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic blank_q, blank, mem_access, req, stall_raw, mem_stall, lu_stall;
  // blank_q keeps every output quiet for the cycle following reset
  assign blank = reset | blank_q;
  assign mem_access = mem_is_load | mem_is_store;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      tmo <= '0;
      cnt <= '0;
      blank_q <= 1'b1;
    end else begin
      state <= state_next;
      tmo <= tmo_next;
      blank_q <= 1'b0;
      if (freeze_front && !(&cnt)) cnt <= cnt + CNT_WIDTH'(1);
    end
  end
  always_comb begin
    state_next = state;
    tmo_next = tmo;
    req = 1'b0;
    stall_raw = 1'b0;
    case (state)
      IDLE: begin
        stall_raw = mem_access & ~blank;
        state_next = stall_raw ? WAIT : IDLE;
        tmo_next = stall_raw ? '0 : tmo;
      end
      WAIT: begin
        req = 1'b1;
        stall_raw = ~dmem_ack;
        state_next = dmem_ack ? IDLE : (tmo == LIM) ? ERROR : WAIT;
        tmo_next = (dmem_ack || tmo == LIM) ? tmo : tmo + 16'd1;
      end
      ERROR: stall_raw = 1'b1;
      default: state_next = IDLE;
    endcase
  end
  assign lu_stall = ~blank & ex_is_load & (ex_write_addr != 5'd0) &
                    ((ex_write_addr == id_rs) | (id_uses_rt & (ex_write_addr == id_rt)));
  assign mem_stall = stall_raw & ~blank;
  assign dmem_req = req & ~blank;
  assign dmem_we = dmem_req & mem_is_store;
  assign freeze_front = mem_stall | lu_stall;
  assign freeze_back = mem_stall;
  assign memwb_bubble = mem_stall;
  assign idex_flush = lu_stall & ~mem_stall;
  assign mem_error = (state == ERROR) & ~blank;
  assign stall_cycle_count = blank ? '0 : cnt;
endmodule

// File: tb/tb_mem_stage_hazard_controller.sv
// tb_mem_stage_hazard_controller: directed checks of handshake, stalls, timeout and reset behaviour.
module tb_mem_stage_hazard_controller;
  logic clock = 0, reset = 1;
  logic mem_is_load = 0, mem_is_store = 0, ex_is_load = 0, id_uses_rt = 0, dmem_ack = 0;
  logic [4:0] ex_write_addr = 0, id_rs = 0, id_rt = 0;
  logic dmem_req, dmem_we, freeze_front, freeze_back, idex_flush, memwb_bubble, mem_error;
  logic [3:0] stall_cycle_count;
  int tests = 0, fails = 0;

  mem_stage_hazard_controller #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
    .ex_is_load(ex_is_load), .ex_write_addr(ex_write_addr), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .freeze_front(freeze_front), .freeze_back(freeze_back), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .mem_error(mem_error), .stall_cycle_count(stall_cycle_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // outputs packed as {req,we,ff,fb,flush,bubble,err}
  task automatic look(input string tag, input logic [6:0] exp, input logic [3:0] cnt_exp);
    #2;
    chk(tag, {dmem_req, dmem_we, freeze_front, freeze_back, idex_flush, memwb_bubble, mem_error}, exp);
    chk({tag, "_cnt"}, stall_cycle_count, cnt_exp);
  endtask

  initial begin
    mem_is_load = 1;
    look("reset_cycle", 7'b0000000, 0);
    cyc(); reset = 0;
    look("post_reset_cycle", 7'b0000000, 0);
    cyc();
    // single load, ack on the 4th WAIT cycle
    look("ld_idle", 7'b0011010, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      look($sformatf("ld_wait%0d", i), 7'b1011010, 4'(i + 1));
    end
    cyc(); dmem_ack = 1;
    look("ld_ack", 7'b1000000, 4);
    cyc(); dmem_ack = 0; mem_is_load = 0;
    look("ld_done", 7'b0000000, 4);
    // store then load back to back
    cyc(); mem_is_store = 1;
    look("st_idle", 7'b0011010, 4);
    cyc(); dmem_ack = 1;
    look("st_ack", 7'b1100000, 5);
    cyc(); mem_is_store = 0; mem_is_load = 1; dmem_ack = 0;
    look("ld2_idle", 7'b0011010, 5);
    cyc(); dmem_ack = 1;
    look("ld2_ack", 7'b1000000, 6);
    cyc(); mem_is_load = 0; dmem_ack = 0;
    look("b2b_done", 7'b0000000, 6);
    // load-use
    ex_is_load = 1; ex_write_addr = 8; id_rs = 8;
    look("lu_rs", 7'b0010100, 6);
    cyc(); ex_write_addr = 0; id_rs = 0;
    look("lu_r0", 7'b0000000, 7);
    cyc(); ex_write_addr = 5; id_rs = 3; id_rt = 5; id_uses_rt = 1;
    look("lu_rt", 7'b0010100, 7);
    cyc(); id_uses_rt = 0;
    look("lu_rt_unused", 7'b0000000, 8);
    // load-use during memory wait
    ex_write_addr = 8; id_rs = 8; mem_is_load = 1;
    look("both_idle", 7'b0011010, 8);
    cyc();
    look("both_wait", 7'b1011010, 9);
    cyc(); dmem_ack = 1;
    look("both_ack", 7'b1010100, 10);
    cyc(); dmem_ack = 0; mem_is_load = 0; ex_is_load = 0;
    look("both_done", 7'b0000000, 11);
    // timeout into ERROR, counter saturates at 15
    mem_is_store = 1;
    look("to_idle", 7'b0011010, 11);
    for (int i = 0; i < 4; i++) begin
      cyc();
      look($sformatf("to_wait%0d", i), 7'b1111010, (i < 3) ? 4'(12 + i) : 4'd15);
    end
    cyc();
    look("to_error", 7'b0011011, 15);
    cyc(); dmem_ack = 1;
    look("to_error_sat", 7'b0011011, 15);
    cyc(); reset = 1; dmem_ack = 0;
    look("to_reset", 7'b0000000, 0);
    cyc(); reset = 0; mem_is_store = 0;
    look("to_after_reset", 7'b0000000, 0);
    cyc();
    look("to_idle_clean", 7'b0000000, 0);
    // reset mid-WAIT, then late ack
    mem_is_load = 1;
    cyc();
    look("mw_wait", 7'b1011010, 1);
    cyc(); reset = 1;
    look("mw_reset", 7'b0000000, 0);
    cyc(); reset = 0; mem_is_load = 0; dmem_ack = 1;
    look("mw_late_ack", 7'b0000000, 0);
    cyc();
    look("mw_late_ack2", 7'b0000000, 0);
    cyc(); dmem_ack = 0;
    look("mw_idle", 7'b0000000, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
